// File: rtl/aes_mask_pkg.sv
// Shared definitions for the masked AES input front-end.
package aes_mask_pkg;

  localparam int unsigned AES_BLK_W = 128;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } ld_state_e;

  // Number of bus beats needed to assemble one AES block.
  function automatic int unsigned beats(input int unsigned bus_w);
    return AES_BLK_W / bus_w;
  endfunction

  // LSB position of share i inside a word of w-bit shares.
  function automatic int unsigned sh_lsb(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

  // MSB position of block slot k; slot 0 sits at the MSB end (AES byte 0 first).
  function automatic int unsigned slot_msb(input int unsigned k, input int unsigned w);
    return AES_BLK_W - 1 - k * w;
  endfunction

endpackage

// File: rtl/aes_mask_refresh.sv
// Combinational remask of one shared word: shares 0..ORDER-1 take one random slice
// each, the last share takes the XOR of all slices so the unmasked value is unchanged.
module aes_mask_refresh
  import aes_mask_pkg::*;
#(
  parameter int unsigned ORDER = 1,
  parameter int unsigned W     = 8
) (
  input  logic [(ORDER+1)*W-1:0] sh_i,
  input  logic [ORDER*W-1:0]     rnd_i,
  output logic [(ORDER+1)*W-1:0] sh_o
);

  // Apply r_j to share j and the accumulated XOR of all r_j to the last share.
  always_comb begin
    logic [W-1:0] acc;
    acc  = '0;
    sh_o = sh_i;
    for (int unsigned j = 0; j < ORDER; j++) begin
      sh_o[sh_lsb(j, W) +: W] = sh_i[sh_lsb(j, W) +: W] ^ rnd_i[sh_lsb(j, W) +: W];
      acc = acc ^ rnd_i[sh_lsb(j, W) +: W];
    end
    sh_o[sh_lsb(ORDER, W) +: W] = sh_i[sh_lsb(ORDER, W) +: W] ^ acc;
  end

endmodule

// File: rtl/aes_masked_block_loader.sv
// Collects BUS_W-bit shared beats of plaintext and key into full 128-bit shared
// blocks and offers them to the masked core over a valid/ready handshake.
module aes_masked_block_loader
  import aes_mask_pkg::*;
#(
  parameter int unsigned ORDER   = 1,
  parameter int unsigned BUS_W   = 8,
  parameter int unsigned REFRESH = 1
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              pk_valid,
  input  logic [(ORDER+1)*BUS_W-1:0]        plain_sh,
  input  logic [(ORDER+1)*BUS_W-1:0]        key_sh,
  input  logic [2*ORDER*BUS_W-1:0]          rnd,
  input  logic                              abort,
  output logic                              in_ready,
  output logic                              blk_valid,
  input  logic                              blk_ready,
  output logic [(ORDER+1)*AES_BLK_W-1:0]    plain_blk,
  output logic [(ORDER+1)*AES_BLK_W-1:0]    key_blk,
  output logic [$clog2(beats(BUS_W)):0]     beat_cnt,
  output logic                              err,
  input  logic                              clr_err
);

  localparam int unsigned SHARES = ORDER + 1;
  localparam int unsigned BEATS  = beats(BUS_W);
  localparam int unsigned CNT_W  = $clog2(BEATS) + 1;
  localparam int unsigned SW     = SHARES * BUS_W;
  localparam int unsigned BW     = SHARES * AES_BLK_W;
  localparam int unsigned RW     = ORDER * BUS_W;

  ld_state_e        state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [BW-1:0]    plain_d, plain_q;
  logic [BW-1:0]    key_d, key_q;
  logic             err_d, err_q;
  logic [SW-1:0]    plain_cap, key_cap;

  if (REFRESH != 0) begin : g_refresh
    aes_mask_refresh #(
      .ORDER(ORDER),
      .W    (BUS_W)
    ) u_refresh_plain (
      .sh_i (plain_sh),
      .rnd_i(rnd[RW-1:0]),
      .sh_o (plain_cap)
    );

    aes_mask_refresh #(
      .ORDER(ORDER),
      .W    (BUS_W)
    ) u_refresh_key (
      .sh_i (key_sh),
      .rnd_i(rnd[2*RW-1:RW]),
      .sh_o (key_cap)
    );
  end else begin : g_bypass
    logic unused_rnd;
    assign unused_rnd = ^rnd;
    assign plain_cap  = plain_sh;
    assign key_cap    = key_sh;
  end

  // FSM next state, beat counter and slot writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    plain_d = plain_q;
    key_d   = key_q;
    unique case (state_q)
      FILL: begin
        if (abort) begin
          // Abort wins over a simultaneous beat; stale slot data is simply overwritten later.
          cnt_d = '0;
        end else if (pk_valid) begin
          for (int unsigned k = 0; k < BEATS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              for (int unsigned i = 0; i < SHARES; i++) begin
                plain_d[sh_lsb(i, AES_BLK_W) + slot_msb(k, BUS_W) -: BUS_W] =
                    plain_cap[sh_lsb(i, BUS_W) +: BUS_W];
                key_d[sh_lsb(i, AES_BLK_W) + slot_msb(k, BUS_W) -: BUS_W] =
                    key_cap[sh_lsb(i, BUS_W) +: BUS_W];
              end
            end
          end
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            state_d = FULL;
            cnt_d   = CNT_W'(BEATS);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FULL: begin
        // Abort is ignored here: an offered block cannot be withdrawn.
        if (blk_ready) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Sticky drop flag; a new violation beats a simultaneous clear.
  always_comb begin
    err_d = (pk_valid & ~in_ready) | (err_q & ~clr_err);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FILL;
      cnt_q   <= '0;
      plain_q <= '0;
      key_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      plain_q <= plain_d;
      key_q   <= key_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q == FULL);
  assign plain_blk = plain_q;
  assign key_blk   = key_q;
  assign beat_cnt  = cnt_q;
  assign err       = err_q;

endmodule
